// File: rtl/bin_to_bcd.sv
// -----------------------------------------------------------------------------
// bin_to_bcd
//
// Purpose:
//    Converts a 16-bit unsigned binary value into four BCD digits. The converter
//    is sequential and uses the shift-and-add-3 (double-dabble) method, one input
//    bit per clock. A five-digit accumulator holds the full range 0..65535.
//    Values above 9999 raise ovf. The SATURATE parameter selects what bcd_out
//    shows on overflow: 9999 (SATURATE=1), or the low four decimal digits
//    (SATURATE=0).
//
// Parameters:
//    SATURATE : 1 = clamp bcd_out to 16'h9999 on overflow.
//               0 = keep the low four decimal digits (bin_in mod 10000).
//
// Ports:
//    clk     in   1   system clock, rising edge
//    rst     in   1   synchronous active-high reset
//    start   in   1   conversion request, sampled only while idle
//    bin_in  in  16   unsigned binary value, captured when start is accepted
//    busy    out  1   high while a conversion is in flight (SHIFT and FIN)
//    done    out  1   one-cycle pulse when bcd_out/ovf take a new result
//    bcd_out out 16   {thousands, hundreds, tens, units}
//    ovf     out  1   the last converted value exceeded 9999
// -----------------------------------------------------------------------------
module bin_to_bcd #(
   parameter int SATURATE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] bin_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] bcd_out,
   output logic        ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FIN   = 2'd2
   } state_t;

   state_t      r_state;
   logic [15:0] r_shiftReg;
   logic [19:0] r_accum;
   logic [4:0]  r_count;
   logic        r_busy;
   logic        r_done;
   logic [15:0] r_bcd;
   logic        r_ovf;

   logic [19:0] w_adjusted;
   logic        w_overflow;
   logic [15:0] w_result;

   // Add-3 correction for every digit of the accumulator. Any digit of 5 or
   // more would become 10 or more when shifted, so adding 3 now makes the shift
   // carry it into the next digit. This keeps every nibble a valid decimal digit.
   always_comb begin
      w_adjusted = r_accum;
      for (int d = 0; d < 5; d++) begin
         if (r_accum[d*4 +: 4] >= 4'd5) begin
            w_adjusted[d*4 +: 4] = r_accum[d*4 +: 4] + 4'd3;
         end
      end
   end

   // A nonzero ten-thousands digit means the value does not fit in four BCD
   // digits. The overflow policy then picks between the clamp value and the
   // low four digits.
   assign w_overflow = (r_accum[19:16] != 4'd0);
   assign w_result   = (w_overflow && (SATURATE != 0)) ? 16'h9999 : r_accum[15:0];

   // Control FSM and datapath registers. The FSM takes a start request only in
   // IDLE. Each SHIFT cycle moves one binary bit into the accumulator. The
   // counter hits zero on the 16th SHIFT edge, and FIN then publishes the
   // result with a single done pulse. Reset has priority over everything and
   // drops any conversion in flight without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_shiftReg <= 16'd0;
         r_accum    <= 20'd0;
         r_count    <= 5'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_bcd      <= 16'h0000;
         r_ovf      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_shiftReg <= bin_in;
                  r_accum    <= 20'd0;
                  r_count    <= 5'd16;
                  r_busy     <= 1'b1;
                  r_state    <= SHIFT;
               end
            end
            SHIFT: begin
               {r_accum, r_shiftReg} <= {w_adjusted, r_shiftReg} << 1;
               r_count <= r_count - 5'd1;
               if (r_count == 5'd1) begin
                  r_state <= FIN;
               end
            end
            FIN: begin
               r_bcd   <= w_result;
               r_ovf   <= w_overflow;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign bcd_out = r_bcd;
   assign ovf     = r_ovf;

endmodule

// File: doc/bin_to_bcd.md
BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 SHALL have parameter: SATURATE, default 1, overflow policy (1 = clamp to 9999, 0 = keep low four decimal digits).
REQ-002 SHALL have port: clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to convert bin_in; sampled only in IDLE.
REQ-005 SHALL have port: bin_in  input  16  unsigned binary value to convert.
REQ-006 SHALL have port: busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port: done  output  1  one-cycle pulse when bcd_out/ovf update; drives the display stage's latch enable.
REQ-008 SHALL have port: bcd_out  output  16  four BCD digits; [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-009 SHALL have port: ovf  output  1  bin_in of last conversion exceeded 9999.

Function
REQ-010 SHALL implement a sequential shift-and-add-3 (double-dabble) converter, one bit per clock, no divide/modulo operators.
REQ-011 SHALL use FSM states IDLE, SHIFT, FIN.
REQ-012 SHALL, in IDLE with start=1 at edge E0: capture bin_in into a 16-bit shift register, clear a 20-bit (5-digit) BCD accumulator, load bit counter to 16, go to SHIFT.
REQ-013 SHALL, in IDLE with start=0, remain in IDLE; bin_in changes SHALL have no effect.
REQ-014 SHALL, on each SHIFT edge: add 3 to every accumulator nibble >= 5, then shift {accumulator, shift register} left by one, decrement counter.
REQ-015 SHALL go SHIFT -> FIN on the edge where the counter reaches 0 (16th SHIFT edge, E16).
REQ-016 SHALL, at the FIN edge (E17): register bcd_out and ovf, assert done for exactly the following cycle, return to IDLE.
REQ-017 SHALL give latency of 17 clocks from the start-sampling edge to done high; minimum start-to-start spacing 18 clocks.
REQ-018 SHALL drive busy=1 in SHIFT and FIN and busy=0 in IDLE, so busy=0 during the done cycle.
REQ-019 SHALL ignore start while busy=1; no queuing, no restart.
REQ-020 SHALL accept a start asserted during the done cycle at the next edge.
REQ-021 SHALL set ovf=1 when the ten-thousands digit is nonzero (bin_in >= 10000), else 0.
REQ-022 SHALL set bcd_out = 16'h9999 when ovf=1 and SATURATE=1.
REQ-023 SHALL set bcd_out = the low four accumulator digits (bin_in mod 10000) when ovf=1 and SATURATE=0.
REQ-024 SHALL hold bcd_out and ovf stable between done pulses.
REQ-025 SHALL keep every accumulator nibble in 0..9 after every SHIFT edge; the five-digit accumulator covers 0..65535 without wrap.

Reset
REQ-026 SHALL, on rst=1 at a clock edge: state=IDLE, busy=0, done=0, bcd_out=16'h0000, ovf=0, counter/shift register/accumulator cleared.
REQ-027 SHALL, on rst during SHIFT or FIN, abort the conversion with no done pulse; rst takes priority over start.
REQ-028 SHALL accept start at the first edge after rst deasserts.

Verification
REQ-029 SHALL cover: start with bin_in=0 -> done exactly 17 clocks later, bcd_out=16'h0000, ovf=0.
REQ-030 SHALL cover: bin_in=1234, then 9999 back-to-back (second start in done cycle) -> 16'h1234 then 16'h9999, ovf=0, done pulses 18 clocks apart.
REQ-031 SHALL cover: SATURATE=1, bin_in=10000 and 65535 -> bcd_out=16'h9999, ovf=1.
REQ-032 SHALL cover: SATURATE=0, bin_in=65535 -> bcd_out=16'h5535, ovf=1; bin_in=10007 -> 16'h0007, ovf=1.
REQ-033 SHALL cover: start pulsed with bin_in=42 while busy after a 777 conversion began -> single done, bcd_out=16'h0777.
REQ-034 SHALL cover: rst at clock 8 of a conversion -> no done, bcd_out=16'h0000, busy=0; next start with 5 -> 16'h0005 after 17 clocks.
